// File: rtl/alpharetz_uart_rx_if.sv
// Purpose : received-word handshake bundle between the UART receiver and its consumer.
// Latency : none, plain wires.
// Backpr. : rx_ready from the consumer holds rx_valid/rx_data until accepted.
interface alpharetz_uart_rx_if #(
  parameter int UART_DATA_WIDTH = 8
) ();
  logic [UART_DATA_WIDTH-1:0] rx_data;
  logic                       rx_valid;
  logic                       rx_ready;
  logic                       parity_err;
  logic                       frame_err;

  // Receiver side drives the word and its qualifiers.
  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    input  rx_ready
  );

  // Consumer side accepts the word.
  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    output rx_ready
  );
endinterface

// File: rtl/alpharetz_uart_rx.sv
// Purpose : oversampling UART receiver (start, LSB-first data, optional even parity, stop).
// Latency : rx_valid rises 1 sys_clk after the enabled cycle sampling the stop bit; line-to-sample skew 3 sys_clk.
// Backpr. : word held until rx_ready; a frame completing while rx_valid is still high is dropped and sets overrun.
// Build option: define ALPHARETZ_UART_RX_PARITY_EN to receive a parity bit after the data.
module alpharetz_uart_rx #(
  parameter int UART_DATA_WIDTH = 8,
  parameter int UART_CLK_RATIO  = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 sys_clk_en,
  input  logic                 uart_rx,
  alpharetz_uart_rx_if.master  rx_if,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int PW = $clog2(UART_CLK_RATIO);
  localparam int BW = $clog2(UART_DATA_WIDTH) + 1;
  localparam logic [PW-1:0] PHASE_MID  = PW'(UART_CLK_RATIO / 2 - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(UART_CLK_RATIO - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(UART_DATA_WIDTH - 1);

`ifdef ALPHARETZ_UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                     state_q, state_d;
  logic                       sync1_q;
  logic                       rx_s;
  logic                       rx_prev_q;
  logic [PW-1:0]              phase_q, phase_d;
  logic [BW-1:0]              bitcnt_q, bitcnt_d;
  logic [UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                       frame_done;
  logic                       ferr_d;
  logic                       fall;

  logic [UART_DATA_WIDTH-1:0] data_q;
  logic                       ferr_q;
  logic                       valid_q;
  logic                       overrun_q;

`ifdef ALPHARETZ_UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic parity_err_q;
`endif

  // Falling edge of the synchronized line; a line already low cannot retrigger.
  assign fall = rx_prev_q & ~rx_s;

  // Two-flop synchronizer plus edge-detect flop, frozen while the enable is low.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else if (sys_clk_en) begin
      sync1_q   <= uart_rx;
      rx_s      <= sync1_q;
      rx_prev_q <= rx_s;
    end
  end

  // FSM state, bit-phase and bit counters, shift register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
`ifdef ALPHARETZ_UART_RX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else if (sys_clk_en) begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
`ifdef ALPHARETZ_UART_RX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  // Next-state logic: start qualification, mid-bit sampling and frame completion.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    ferr_d     = 1'b0;
`ifdef ALPHARETZ_UART_RX_PARITY_EN
    perr_d     = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          phase_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (phase_q == PHASE_MID) begin
          phase_d = '0;
          if (rx_s) begin
            // Line back high at mid start bit: treat as a glitch.
            state_d = IDLE;
          end else begin
            bitcnt_d = '0;
            state_d  = DATA;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      DATA: begin
        if (phase_q == PHASE_LAST) begin
          phase_d  = '0;
          shift_d  = {rx_s, shift_q[UART_DATA_WIDTH-1:1]};
          bitcnt_d = bitcnt_q + BW'(1);
          if (bitcnt_q == BIT_LAST) begin
`ifdef ALPHARETZ_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
`ifdef ALPHARETZ_UART_RX_PARITY_EN
      PARITY: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          perr_d  = rx_s ^ (^shift_q);
          state_d = STOP;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
`endif
      STOP: begin
        if (phase_q == PHASE_LAST) begin
          phase_d    = '0;
          frame_done = 1'b1;
          ferr_d     = ~rx_s;
          state_d    = IDLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Output word register, valid handshake and sticky overrun.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      ferr_q       <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef ALPHARETZ_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else if (sys_clk_en) begin
      if (frame_done) begin
        if (!valid_q || rx_if.rx_ready) begin
          data_q       <= shift_q;
          ferr_q       <= ferr_d;
          valid_q      <= 1'b1;
`ifdef ALPHARETZ_UART_RX_PARITY_EN
          parity_err_q <= perr_q;
`endif
        end
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end
      // Set beats clear when both happen on the same cycle.
      if (frame_done && valid_q && !rx_if.rx_ready) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_if.frame_err = ferr_q;
`ifdef ALPHARETZ_UART_RX_PARITY_EN
  assign rx_if.parity_err = parity_err_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif
  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alpharetz_uart_rx.sv
// Purpose : self-checking bench for alpharetz_uart_rx, directed cases plus random frames.
// Latency : expectations taken after each frame's stop bit has been fully driven.
// Backpr. : bench drives rx_ready and overrun_clr explicitly per case.
module tb_alpharetz_uart_rx;

`ifdef ALPHARETZ_UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic sys_clk     = 1'b0;
  logic rst_n       = 1'b0;
  logic sys_clk_en  = 1'b1;
  logic uart_rx     = 1'b1;
  logic overrun_clr = 1'b0;
  logic overrun;
  logic busy;
  bit   en_div2     = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  alpharetz_uart_rx_if #(.UART_DATA_WIDTH(8)) rx_if ();

  alpharetz_uart_rx #(
    .UART_DATA_WIDTH(8),
    .UART_CLK_RATIO (16)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .sys_clk_en (sys_clk_en),
    .uart_rx    (uart_rx),
    .rx_if      (rx_if),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Clock enable: always high, or alternating when en_div2 is set.
  initial begin
    forever begin
      @(negedge sys_clk);
      sys_clk_en = en_div2 ? ~sys_clk_en : 1'b1;
    end
  end

  // Hard stop in case something wedges.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Reference model: expected flags from the frame as sent.
  function automatic logic exp_perr(input logic [7:0] d, input logic p);
    return PAR_EN ? (p ^ (^d)) : 1'b0;
  endfunction

  // Drive one frame: idle gap, start, data LSB first, parity (if built), stop, then idle high.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int spb);
    uart_rx = 1'b1;
    hold(2 * spb);
    uart_rx = 1'b0;
    hold(spb);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      hold(spb);
    end
    if (PAR_EN) begin
      uart_rx = p;
      hold(spb);
    end
    uart_rx = s;
    hold(spb);
    uart_rx = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (rx_if.rx_valid !== 1'b1 && n < 200) begin
      hold(1);
      n++;
    end
    check_eq(tag, {31'd0, rx_if.rx_valid}, 32'd1);
  endtask

  task automatic accept(input string tag);
    int n;
    rx_if.rx_ready = 1'b1;
    n = 0;
    do begin
      hold(1);
      n++;
    end while (rx_if.rx_valid === 1'b1 && n < 8);
    rx_if.rx_ready = 1'b0;
    check_eq(tag, {31'd0, rx_if.rx_valid}, 32'd0);
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d, input logic p, input logic s);
    wait_valid({tag, "_valid"});
    check_eq({tag, "_data"}, {24'd0, rx_if.rx_data}, {24'd0, d});
    check_eq({tag, "_perr"}, {31'd0, rx_if.parity_err}, {31'd0, exp_perr(d, p)});
    check_eq({tag, "_ferr"}, {31'd0, rx_if.frame_err}, {31'd0, ~s});
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;

    rx_if.rx_ready = 1'b0;
    hold(3);
    rst_n = 1'b1;
    hold(3);

    // Reset state.
    check_eq("rst_valid",   {31'd0, rx_if.rx_valid},   32'd0);
    check_eq("rst_data",    {24'd0, rx_if.rx_data},    32'd0);
    check_eq("rst_perr",    {31'd0, rx_if.parity_err}, 32'd0);
    check_eq("rst_ferr",    {31'd0, rx_if.frame_err},  32'd0);
    check_eq("rst_overrun", {31'd0, overrun},          32'd0);
    check_eq("rst_busy",    {31'd0, busy},             32'd0);

    // Clean frame 0xA5, held until accepted.
    send_frame(8'hA5, ^8'hA5, 1'b1, 16);
    expect_word("a5", 8'hA5, ^8'hA5, 1'b1);
    hold(20);
    check_eq("a5_hold", {31'd0, rx_if.rx_valid}, 32'd1);
    accept("a5_accept");

    // Short low pulse must not produce a word.
    uart_rx = 1'b0;
    hold(6);
    uart_rx = 1'b1;
    hold(40);
    check_eq("glitch_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check_eq("glitch_busy",  {31'd0, busy},           32'd0);
    send_frame(8'h3C, ^8'h3C, 1'b1, 16);
    expect_word("x3c", 8'h3C, ^8'h3C, 1'b1);
    accept("x3c_accept");

    // Wrong parity and zero stop bit: word still delivered with both flags.
    send_frame(8'h01, 1'b0, 1'b0, 16);
    expect_word("x01", 8'h01, 1'b0, 1'b0);
    accept("x01_accept");

    // Two frames without accepting: first word kept, overrun set, then cleared.
    send_frame(8'h11, ^8'h11, 1'b1, 16);
    send_frame(8'h22, ^8'h22, 1'b1, 16);
    hold(4);
    check_eq("ovr_data",  {24'd0, rx_if.rx_data},  32'h11);
    check_eq("ovr_valid", {31'd0, rx_if.rx_valid}, 32'd1);
    check_eq("ovr_set",   {31'd0, overrun},        32'd1);
    hold(10);
    check_eq("ovr_sticky", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    hold(1);
    overrun_clr = 1'b0;
    check_eq("ovr_clr", {31'd0, overrun}, 32'd0);
    accept("ovr_accept");

    // Leave a word pending, then reset in the 4th data bit of the next frame.
    send_frame(8'h5A, ^8'h5A, 1'b1, 16);
    wait_valid("pend_valid");
    d = 8'h96;
    uart_rx = 1'b1;
    hold(32);
    uart_rx = 1'b0;
    hold(16);
    for (int i = 0; i < 3; i++) begin
      uart_rx = d[i];
      hold(16);
    end
    uart_rx = d[3];
    hold(8);
    check_eq("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check_eq("midrst_busy",  {31'd0, busy},           32'd0);
    uart_rx = 1'b1;
    hold(4);
    rst_n = 1'b1;
    hold(4);
    send_frame(8'h7E, ^8'h7E, 1'b1, 16);
    expect_word("x7e", 8'h7E, ^8'h7E, 1'b1);
    accept("x7e_accept");

    // Half-rate enable: 32 sys_clk per bit.
    en_div2 = 1'b1;
    send_frame(8'hC3, ^8'hC3, 1'b1, 32);
    expect_word("c3_div2", 8'hC3, ^8'hC3, 1'b1);
    accept("c3_div2_accept");
    en_div2 = 1'b0;
    hold(4);

    // Random frames with occasional bad parity or stop.
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s, 16);
      expect_word("rnd", d, p, s);
      accept("rnd_accept");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alpharetz_uart_rx.md
Name: alpharetz_uart_rx

Overview:
UART receiver that consumes the serial line driven by the Alpharetz UART transmitter, or by an external device, and delivers parallel words to the CPU.
- Oversamples the line with the system clock, qualified by sys_clk_en.
- Frame: start bit 0, UART_DATA_WIDTH data bits LSB first, optional even-parity bit, stop bit 1.
- Presents each received word on a valid/ready handshake with per-word error flags.

Parameters:
UART_DATA_WIDTH, 8, data bits per frame
UART_CLK_RATIO, 16, enabled sys_clk cycles per bit period (>=4, even)

Ports:
sys_clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
sys_clk_en  in  1  clock enable; all state, counters and sampling advance only when high
uart_rx  in  1  serial line from device, idle high, asynchronous to sys_clk
rx_data  out  UART_DATA_WIDTH  received word, stable while rx_valid=1
rx_valid  out  1  word available
rx_ready  in  1  CPU accepts word; transfer occurs when rx_valid & rx_ready on an enabled cycle
parity_err  out  1  qualifies rx_data; parity mismatch on this word
frame_err  out  1  qualifies rx_data; stop bit sampled 0
overrun  out  1  sticky; a completed frame was dropped because rx_valid was still high
overrun_clr  in  1  clears overrun (enabled cycle)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - Counters, rx_data, parity_err, frame_err, rx_valid, overrun=0.
  - Both synchronizer flops=1.
- Synchronizer: uart_rx passes through a 2-flop synchronizer, then one edge-detect flop. All decisions use the synchronized value rx_s.
- Counters:
  - Bit-phase counter, width $clog2(UART_CLK_RATIO), wraps at UART_CLK_RATIO-1.
  - Bit counter, width $clog2(UART_DATA_WIDTH)+1.
- FSM (transitions on enabled cycles only):
  - IDLE:
    - On a falling edge of rx_s (previous 1, current 0): phase=0, go to START.
    - A line held low does not retrigger.
  - START:
    - At phase=UART_CLK_RATIO/2-1 (mid-bit), sample rx_s.
    - If 1: glitch; return to IDLE with no output.
    - If 0: phase=0, bitcnt=0, go to DATA.
  - DATA:
    - At each mid-bit (phase=UART_CLK_RATIO-1 counted from the previous mid-bit), shift rx_s into the MSB of the shift register and shift right.
    - After UART_DATA_WIDTH samples, go to PARITY (macro on) or STOP.
  - PARITY: at mid-bit, sample p; perr = p ^ (XOR of shift register); go to STOP.
  - STOP:
    - At mid-bit, sample s; ferr = ~s.
    - Frame completes; go to IDLE on the same cycle.
    - The next start edge may be detected from the following enabled cycle.
- Completion:
  - If rx_valid=0, or rx_valid & rx_ready on the same cycle: on the next edge, rx_data=shift register, parity_err=perr, frame_err=ferr, rx_valid=1.
  - Otherwise the frame is dropped and overrun<=1. rx_data and its flags are unchanged.
- Handshake:
  - rx_valid holds until accepted.
  - rx_valid & rx_ready with no simultaneous completion: rx_valid<=0.
  - rx_data, parity_err and frame_err do not change while rx_valid=1 unless a simultaneous completion replaces them.
- Overrun:
  - Sticky.
  - overrun_clr clears it.
  - Set and clear on the same cycle: set wins.
- Latency: rx_valid rises 1 sys_clk after the enabled cycle that samples the stop bit. Input-to-sample skew is 3 sys_clk (synchronizer plus edge flop).
- A frame error still delivers the word, with frame_err=1.
- sys_clk_en low: everything freezes, including the synchronizer. rx_valid and the outputs hold.
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
ALPHARETZ_UART_RX_PARITY_EN
- Defined: frame includes one even-parity bit after the data; PARITY state exists; parity_err as specified.
- Undefined: no PARITY state; DATA goes to STOP directly; parity_err is constant 0.

Test Plan:
- Defaults, parity on, sys_clk_en=1. Send 0xA5 with parity 0 and stop 1, bits at 16-cycle spacing, rx_ready=0 → rx_valid=1, rx_data=0xA5, parity_err=0, frame_err=0. Then rx_ready=1 for one cycle → rx_valid=0.
- Glitch: uart_rx low for 6 cycles, then high → no rx_valid; busy returns to 0; the next valid frame 0x3C is received correctly.
- Send 0x01 with parity bit 0 (wrong) and stop bit 0 → rx_data=0x01, parity_err=1, frame_err=1.
- Send 0x11 then 0x22 back-to-back with rx_ready=0 → rx_data stays 0x11, overrun=1. After overrun_clr, overrun=0.
- Assert rst_n=0 in the 4th data bit of a frame → rx_valid=0 and busy=0 immediately. A subsequent frame 0x7E is received correctly.
- sys_clk_en toggled 1-of-2 with bit spacing of 32 sys_clk; send 0xC3 → rx_data=0xC3, no errors. Repeat with the macro undefined and a frame without parity → 0xC3, parity_err=0.
